mhost_bus: RTL
==============

MHOST_BUS -- requirements
Module: mhost_bus

Interface
REQ-001 Parameter NrHosts, default 2: number of requesting hosts, range 1..8.
REQ-002 Parameter NrDevices, default 3: number of target devices, range 1..16.
REQ-003 Parameter DataWidth, default 32: data bus width in bits.
REQ-004 Parameter AddressWidth, default 32: address bus width in bits.
REQ-005 Parameter ArbMode, default 1: arbitration mode; 0 = fixed priority (lowest index wins), 1 = round robin.
REQ-006 Ports SHALL be as follows; per-host and per-device fields are packed with index 0 in the LSBs.
- clk_i  in  1  system clock; one clock, all logic on its rising edge
- rst_i  in  1  reset; synchronous, active-high
- host_req_i  in  NrHosts  request per host
- host_addr_i  in  NrHosts*AW  byte address
- host_we_i  in  NrHosts  1 = write
- host_be_i  in  NrHosts*DW/8  byte enables
- host_wdata_i  in  NrHosts*DW  write data
- host_gnt_o  out  NrHosts  grant, one-hot or zero
- host_rvalid_o  out  NrHosts  response valid
- host_rdata_o  out  NrHosts*DW  read data
- host_err_o  out  NrHosts  response error
- device_req_o  out  NrDevices  request per device
- device_addr_o  out  NrDevices*AW  address, passed through unmodified
- device_we_o / device_be_o / device_wdata_o  out  per-device copies of the granted host's fields
- device_rvalid_i  in  NrDevices  device response valid
- device_rdata_i  in  NrDevices*DW  device read data
- device_err_i  in  NrDevices  device error
- cfg_device_addr_base_i  in  NrDevices*AW  base address per device
- cfg_device_addr_mask_i  in  NrDevices*AW  decode mask per device

Function
REQ-010 Device d SHALL match when (addr & mask[d]) == base[d]; if several devices match, the lowest index SHALL win.
REQ-011 At most one host SHALL be granted per cycle; host_gnt_o and device_req_o are combinational from the current requests and arbiter state.
REQ-012 In ArbMode 1, a round-robin pointer SHALL give the highest priority to host ptr; after a grant to host h, ptr SHALL become (h+1) mod NrHosts on the next edge; ptr is unchanged when there is no grant.
REQ-013 In ArbMode 0, ptr SHALL be unused and host 0 SHALL have the highest priority.
REQ-014 A granted request to a matched device SHALL assert device_req_o[d] in the same cycle, carrying the granted host's addr, we, be and wdata; all other device_req_o bits SHALL be 0.
REQ-015 Device-side fields for non-selected devices SHALL be driven 0.
REQ-016 Devices respond exactly 1 cycle after req. The block SHALL register the tuple (valid, host, device, unmapped) of each grant.
- The following cycle, host_rvalid_o[host] SHALL equal device_rvalid_i[device].
- host_rdata_o[host] SHALL equal device_rdata_i[device] and host_err_o[host] SHALL equal device_err_i[device].
REQ-017 A granted request that matches no device SHALL assert no device_req_o; one cycle later the block SHALL return host_rvalid=1, host_err=1, rdata=0.
REQ-018 Back-to-back grants on consecutive cycles SHALL be supported; a response and a new grant in the same cycle are independent.
REQ-019 device_rvalid_i with no registered pending grant, or from a device other than the registered one, SHALL be ignored.
REQ-020 Unaddressed host outputs SHALL be 0 each cycle.
REQ-021 A host whose request is not granted SHALL hold its request; the block does not queue requests.

Reset
REQ-030 While rst_i is high at a clock edge, ptr SHALL be set to 0 and the pending tuple cleared.
REQ-031 In the cycle following reset, host_rvalid_o, host_err_o and host_rdata_o SHALL be 0.
REQ-032 Reset asserted mid-transaction SHALL drop the pending response; no rvalid is delivered for it.
REQ-033 During reset, the grant outputs SHALL still evaluate combinationally from ptr = 0.

Structure
REQ-040 A shared package bus_pkg SHALL hold the ArbMode constants (ARB_FIXED = 0, ARB_RR = 1) and the clog2-based index width helpers.
REQ-041 Arbitration SHALL live in one sub-module, rr_arbiter: inputs req, ArbMode and ptr; outputs a one-hot gnt plus the granted index.

Verification
REQ-050 All scenarios use NrHosts=2, NrDevices=3, bases 0x100000/0x200000/0x300000, mask 0xFFF00000.
- Both hosts request 0x100004 every cycle in ArbMode 1 -> grants alternate H0,H1,H0,H1; each rvalid returns to the matching host 1 cycle later.
- Same stimulus in ArbMode 0 -> H0 is granted every cycle and H1 is never granted.
- H0 reads 0x400000 (unmapped) -> no device_req; next cycle host_rvalid[0]=1, err=1, rdata=0.
- H1 writes 0x200000 with be=0x1, wdata=0x41 -> device_req[1]=1 with be=0x1, wdata=0x41; the device rvalid is routed to host 1 only.
- Grant to the timer device at 0x300008, then rst_i high on the next edge -> no host_rvalid; after reset, ptr=0 and the first grant goes to H0.
- A spurious device_rvalid_i[2] with nothing pending -> all host_rvalid_o remain 0.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared constants and index-width helpers for the multi-host bus.
package bus_pkg;

    localparam int unsigned ARB_FIXED = 0;
    localparam int unsigned ARB_RR    = 1;

    // Width of an index into n items; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Single-grant arbiter: fixed priority from host 0, or round robin starting at ptr_i.
module rr_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned NrHosts = 2,
    parameter int unsigned IdxW    = idx_width(NrHosts)
) (
    input  logic [NrHosts-1:0] req_i,
    input  logic               arb_mode_i,
    input  logic [IdxW-1:0]    ptr_i,
    output logic [NrHosts-1:0] gnt_o,
    output logic [IdxW-1:0]    gnt_idx_o,
    output logic               gnt_valid_o
);

    always_comb begin
        int unsigned cand;
        logic [IdxW-1:0] cidx;
        cand        = 0;
        cidx        = '0;
        gnt_o       = '0;
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        for (int unsigned i = 0; i < NrHosts; i++) begin
            cand = arb_mode_i ? 32'(ptr_i) + i : i;
            if (cand >= NrHosts) cand = cand - NrHosts;
            cidx = cand[IdxW-1:0];
            if (!gnt_valid_o && req_i[cidx]) begin
                gnt_valid_o = 1'b1;
                gnt_o[cidx] = 1'b1;
                gnt_idx_o   = cidx;
            end
        end
    end

endmodule

// File: rtl/mhost_bus.sv
// Multi-host to multi-device bus: arbitrate, decode, forward, and route the
// one-cycle-later device response back to the granted host.
module mhost_bus
    import bus_pkg::*;
#(
    parameter int unsigned NrHosts      = 2,
    parameter int unsigned NrDevices    = 3,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned AddressWidth = 32,
    parameter int unsigned ArbMode      = 1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NrHosts-1:0]                host_req_i,
    input  logic [NrHosts*AddressWidth-1:0]   host_addr_i,
    input  logic [NrHosts-1:0]                host_we_i,
    input  logic [NrHosts*DataWidth/8-1:0]    host_be_i,
    input  logic [NrHosts*DataWidth-1:0]      host_wdata_i,
    output logic [NrHosts-1:0]                host_gnt_o,
    output logic [NrHosts-1:0]                host_rvalid_o,
    output logic [NrHosts*DataWidth-1:0]      host_rdata_o,
    output logic [NrHosts-1:0]                host_err_o,
    output logic [NrDevices-1:0]              device_req_o,
    output logic [NrDevices*AddressWidth-1:0] device_addr_o,
    output logic [NrDevices-1:0]              device_we_o,
    output logic [NrDevices*DataWidth/8-1:0]  device_be_o,
    output logic [NrDevices*DataWidth-1:0]    device_wdata_o,
    input  logic [NrDevices-1:0]              device_rvalid_i,
    input  logic [NrDevices*DataWidth-1:0]    device_rdata_i,
    input  logic [NrDevices-1:0]              device_err_i,
    input  logic [NrDevices*AddressWidth-1:0] cfg_device_addr_base_i,
    input  logic [NrDevices*AddressWidth-1:0] cfg_device_addr_mask_i
);

    localparam int unsigned HostIdxW = idx_width(NrHosts);
    localparam int unsigned DevIdxW  = idx_width(NrDevices);
    localparam int unsigned BeW      = DataWidth / 8;

    logic [HostIdxW-1:0] ptr_q, ptr_d, ptr_eff, gnt_idx;
    logic                gnt_valid;

    // Grants during reset already behave as if the pointer were cleared.
    assign ptr_eff = rst_i ? '0 : ptr_q;

    rr_arbiter #(
        .NrHosts(NrHosts),
        .IdxW   (HostIdxW)
    ) u_arb (
        .req_i      (host_req_i),
        .arb_mode_i (ArbMode == ARB_RR),
        .ptr_i      (ptr_eff),
        .gnt_o      (host_gnt_o),
        .gnt_idx_o  (gnt_idx),
        .gnt_valid_o(gnt_valid)
    );

    logic [AddressWidth-1:0] sel_addr;
    logic                    sel_we;
    logic [BeW-1:0]          sel_be;
    logic [DataWidth-1:0]    sel_wdata;
    logic                    dev_hit;
    logic [DevIdxW-1:0]      dev_idx;

    always_comb begin
        sel_addr  = host_addr_i[gnt_idx*AddressWidth +: AddressWidth];
        sel_we    = host_we_i[gnt_idx];
        sel_be    = host_be_i[gnt_idx*BeW +: BeW];
        sel_wdata = host_wdata_i[gnt_idx*DataWidth +: DataWidth];
        dev_hit   = 1'b0;
        dev_idx   = '0;
        // Scan downwards so the lowest matching index is the one kept.
        for (int d = NrDevices - 1; d >= 0; d--) begin
            if ((sel_addr & cfg_device_addr_mask_i[d*AddressWidth +: AddressWidth]) ==
                cfg_device_addr_base_i[d*AddressWidth +: AddressWidth]) begin
                dev_hit = 1'b1;
                dev_idx = DevIdxW'(d);
            end
        end
    end

    always_comb begin
        device_req_o   = '0;
        device_addr_o  = '0;
        device_we_o    = '0;
        device_be_o    = '0;
        device_wdata_o = '0;
        for (int unsigned d = 0; d < NrDevices; d++) begin
            if (gnt_valid && dev_hit && dev_idx == DevIdxW'(d)) begin
                device_req_o[d]                                = 1'b1;
                device_addr_o[d*AddressWidth +: AddressWidth]  = sel_addr;
                device_we_o[d]                                 = sel_we;
                device_be_o[d*BeW +: BeW]                      = sel_be;
                device_wdata_o[d*DataWidth +: DataWidth]       = sel_wdata;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (ArbMode == ARB_RR && gnt_valid) begin
            ptr_d = (gnt_idx == HostIdxW'(NrHosts - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    logic                pend_valid_q;
    logic [HostIdxW-1:0] pend_host_q;
    logic [DevIdxW-1:0]  pend_dev_q;
    logic                pend_unmapped_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q           <= '0;
            pend_valid_q    <= 1'b0;
            pend_host_q     <= '0;
            pend_dev_q      <= '0;
            pend_unmapped_q <= 1'b0;
        end else begin
            ptr_q           <= ptr_d;
            pend_valid_q    <= gnt_valid;
            pend_host_q     <= gnt_idx;
            pend_dev_q      <= dev_idx;
            pend_unmapped_q <= !dev_hit;
        end
    end

    always_comb begin
        host_rvalid_o = '0;
        host_err_o    = '0;
        host_rdata_o  = '0;
        for (int unsigned h = 0; h < NrHosts; h++) begin
            if (pend_valid_q && pend_host_q == HostIdxW'(h)) begin
                if (pend_unmapped_q) begin
                    host_rvalid_o[h] = 1'b1;
                    host_err_o[h]    = 1'b1;
                end else begin
                    host_rvalid_o[h] = device_rvalid_i[pend_dev_q];
                    host_err_o[h]    = device_err_i[pend_dev_q];
                    host_rdata_o[h*DataWidth +: DataWidth] =
                        device_rdata_i[pend_dev_q*DataWidth +: DataWidth];
                end
            end
        end
    end

endmodule
